// File: rtl/reg_file_sb_pkg.sv
// Shared defaults for the register-file slice (datapath and control FSM).
//   REGISTER_WIDTH  : default data width of each architectural register
//   REGISTER_COUNT  : default number of architectural registers
//   REG_INDEX_WIDTH : default register index width
package reg_file_sb_pkg;
  localparam int REGISTER_WIDTH  = 32;
  localparam int REGISTER_COUNT  = 32;
  localparam int REG_INDEX_WIDTH = 5;

  // Width of a count that can reach REGISTER_COUNT without wrapping.
  localparam int PENDING_WIDTH = REG_INDEX_WIDTH + 1;
endpackage

// File: rtl/reg_file_sb_scoreboard.sv
// rf_scoreboard: per-register busy bits, issue acceptance and pending count.
//   clk, rst          : clock, synchronous active-high reset
//   wr_en/wr_reg_index: writeback strobe and destination (clears busy)
//   iss_en/iss_reg_index: issue request and destination (sets busy)
//   flush             : clear every busy bit
//   busy              : busy vector zero-extended to the full index space
//   wr_ok             : writeback targets a real, writable register
//   iss_ok            : issue accepted this cycle
//   pending_cnt       : number of busy registers
module rf_scoreboard
  import reg_file_sb_pkg::*;
#(
  parameter int REG_COUNT = REGISTER_COUNT,
  parameter int IDX_WIDTH = REG_INDEX_WIDTH,
  parameter int ZERO_REG  = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [IDX_WIDTH-1:0]     wr_reg_index,
  input  logic                     iss_en,
  input  logic [IDX_WIDTH-1:0]     iss_reg_index,
  input  logic                     flush,
  output logic [(1<<IDX_WIDTH)-1:0] busy,
  output logic                     wr_ok,
  output logic                     iss_ok,
  output logic [IDX_WIDTH:0]       pending_cnt
);
  localparam int DEPTH = 1 << IDX_WIDTH;

  logic [REG_COUNT-1:0] r_busy;
  logic [IDX_WIDTH:0]   r_cnt;
  logic                 w_iss_tgt_ok;
  logic                 w_set;
  logic                 w_inc;
  logic                 w_dec;

  // Real, writable register: in range and not the hard-wired zero register.
  function automatic logic idx_ok(input logic [IDX_WIDTH-1:0] idx);
    return (int'(idx) < REG_COUNT) && !((ZERO_REG != 0) && (idx == '0));
  endfunction

  // Padding to the full index space lets any index be looked up safely;
  // the padded bits are constant 0, so out-of-range never looks busy.
  assign busy         = DEPTH'(r_busy);
  assign wr_ok        = wr_en && idx_ok(wr_reg_index);
  assign w_iss_tgt_ok = idx_ok(iss_reg_index);

  // A busy target may still be issued if this cycle's writeback frees it.
  assign iss_ok = iss_en && !flush &&
                  (!w_iss_tgt_ok || !busy[iss_reg_index] ||
                   (wr_en && (wr_reg_index == iss_reg_index)));
  assign w_set  = iss_ok && w_iss_tgt_ok;

  // Same-index write+issue leaves the bit set: neither count step applies.
  assign w_inc  = w_set && !busy[iss_reg_index];
  assign w_dec  = wr_ok && busy[wr_reg_index] &&
                  !(w_set && (iss_reg_index == wr_reg_index));

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_busy <= '0;
      r_cnt  <= '0;
    end else begin
      for (int i = 0; i < REG_COUNT; i++) begin
        if (wr_ok && (int'(wr_reg_index) == i))  r_busy[i] <= 1'b0;
        if (w_set && (int'(iss_reg_index) == i)) r_busy[i] <= 1'b1;
      end
      r_cnt <= r_cnt + (IDX_WIDTH+1)'(w_inc) - (IDX_WIDTH+1)'(w_dec);
    end
  end

  assign pending_cnt = r_cnt;
endmodule

// File: rtl/reg_file_sb.sv
// reg_file_sb: multi-read-port register file with busy scoreboard and
// write-to-read bypass.
//   clk, rst       : clock, synchronous active-high reset
//   rd_reg_index   : NUM_RD packed read indices
//   reg_data       : NUM_RD packed read data (combinational)
//   rd_ready       : per-port operand valid this cycle
//   wr_en/wr_reg_index/wr_reg_data : writeback
//   iss_en/iss_reg_index/iss_ok    : issue request / acceptance
//   flush          : clear all busy bits (data kept)
//   pending_cnt    : number of busy registers
module reg_file_sb
  import reg_file_sb_pkg::*;
#(
  parameter int REG_WIDTH = REGISTER_WIDTH,
  parameter int REG_COUNT = REGISTER_COUNT,
  parameter int IDX_WIDTH = REG_INDEX_WIDTH,
  parameter int NUM_RD    = 2,
  parameter int ZERO_REG  = 1,
  parameter int BYPASS    = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_RD*IDX_WIDTH-1:0]   rd_reg_index,
  output logic [NUM_RD*REG_WIDTH-1:0]   reg_data,
  output logic [NUM_RD-1:0]             rd_ready,
  input  logic                          wr_en,
  input  logic [IDX_WIDTH-1:0]          wr_reg_index,
  input  logic [REG_WIDTH-1:0]          wr_reg_data,
  input  logic                          iss_en,
  input  logic [IDX_WIDTH-1:0]          iss_reg_index,
  output logic                          iss_ok,
  input  logic                          flush,
  output logic [IDX_WIDTH:0]            pending_cnt
);
  logic [REG_WIDTH-1:0]          r_mem [REG_COUNT];
  logic [(1<<IDX_WIDTH)-1:0]     w_busy;
  logic                          w_wr_ok;

  rf_scoreboard #(
    .REG_COUNT (REG_COUNT),
    .IDX_WIDTH (IDX_WIDTH),
    .ZERO_REG  (ZERO_REG)
  ) u_sb (
    .clk           (clk),
    .rst           (rst),
    .wr_en         (wr_en),
    .wr_reg_index  (wr_reg_index),
    .iss_en        (iss_en),
    .iss_reg_index (iss_reg_index),
    .flush         (flush),
    .busy          (w_busy),
    .wr_ok         (w_wr_ok),
    .iss_ok        (iss_ok),
    .pending_cnt   (pending_cnt)
  );

  // Dropped writes (reg0 / out of range) never touch the array.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_COUNT; i++) r_mem[i] <= '0;
    end else if (w_wr_ok) begin
      r_mem[wr_reg_index] <= wr_reg_data;
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [IDX_WIDTH-1:0] w_idx;
    logic                 w_const0;
    logic                 w_byp;

    assign w_idx    = rd_reg_index[p*IDX_WIDTH +: IDX_WIDTH];
    assign w_const0 = (int'(w_idx) >= REG_COUNT) ||
                      ((ZERO_REG != 0) && (w_idx == '0));
    assign w_byp    = (BYPASS != 0) && wr_en && (wr_reg_index == w_idx);

    always_comb begin
      reg_data[p*REG_WIDTH +: REG_WIDTH] = '0;
      rd_ready[p]                        = 1'b1;
      if (w_const0) begin
        reg_data[p*REG_WIDTH +: REG_WIDTH] = '0;
      end else if (w_byp) begin
        reg_data[p*REG_WIDTH +: REG_WIDTH] = wr_reg_data;
      end else begin
        reg_data[p*REG_WIDTH +: REG_WIDTH] = r_mem[w_idx];
        rd_ready[p]                        = !w_busy[w_idx];
      end
    end
  end
endmodule
